neuron_array_sched: RTL and testbench
=====================================

// Module: neuron_array_sched
// PURPOSE
//  Time-multiplexes one shared single-neuron update datapath (the fixed-point LIF step) across NUM_NEURONS state slots.
//  Holds per-neuron membrane voltage, bias current and refractory count.
//  On each timestep strobe it sweeps all neurons through the datapath over a req/ack port.
//  Detects threshold crossings, emits spike events and applies reset/refractory. Sits between the timestep generator and the spike router.
// PARAMETERS
//  NUM_NEURONS  16      neuron slots swept per tick (>=2)
//  V_W          16      signed width of voltage/current words, Q8.8
//  V_THRESH     -9830   spike threshold, Q8.8 (-38.4); spike when v_next > V_THRESH
//  V_RESET      -16640  post-spike / power-on voltage, Q8.8 (-65.0)
//  REFRAC_CYC   5       ticks a neuron is held at V_RESET after spiking (>=1)
// PORTS
//  clk          in   1                   clock
//  rst_n        in   1                   async active-low reset
//  tick_i       in   1                   timestep strobe, 1-cycle pulse
//  cfg_we_i     in   1                   bias write enable
//  cfg_idx_i    in   $clog2(NUM_NEURONS) bias write index
//  cfg_bias_i   in   V_W                 bias current, Q8.8 signed
//  dp_req_o     out  1                   datapath request
//  dp_idx_o     out  $clog2(NUM_NEURONS) neuron index in flight
//  dp_v_o       out  V_W                 current voltage to datapath
//  dp_i_o       out  V_W                 bias current to datapath
//  dp_ack_i     in   1                   datapath accept, result valid same cycle
//  dp_v_next_i  in   V_W                 updated voltage from datapath
//  spike_vld_o  out  1                   spike event pulse
//  spike_idx_o  out  $clog2(NUM_NEURONS) spiking neuron index
//  busy_o       out  1                   sweep in progress
//  done_o       out  1                   1-cycle pulse, sweep finished
//  overrun_o    out  1                   sticky: tick_i arrived while busy
// BEHAVIOUR
//  Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
//  Reset values:
//   - all V slots = V_RESET; biases = 0; refractory counts = 0.
//   - state IDLE; idx = 0.
//   - every output 0, including overrun_o.
//  FSM IDLE -> SEL -> ISSUE -> WB -> (SEL | DONE) -> IDLE.
//   - IDLE: tick_i moves to SEL with idx = 0.
//   - SEL: if refrac[idx] != 0, skip the datapath and go straight to WB; else go to ISSUE.
//   - ISSUE: dp_req_o = 1.
//     - dp_idx_o, dp_v_o and dp_i_o stay stable until a cycle where dp_ack_i = 1.
//     - In that cycle, capture dp_v_next_i and go to WB.
//     - No timeout.
//   - WB, for a refractory neuron: V = V_RESET, refrac -= 1.
//   - WB, when v_next > V_THRESH (signed compare): V = V_RESET, refrac = REFRAC_CYC, spike_vld_o = 1, spike_idx_o = idx.
//   - WB, otherwise: V = v_next.
//   - WB exit: idx == NUM_NEURONS-1 goes to DONE; else idx += 1 and go to SEL.
//   - DONE: done_o = 1 for one cycle, then IDLE.
//  busy_o = 1 in every state except IDLE.
//  Latency per neuron:
//   - 3 cycles plus ack wait (SEL, ISSUE, WB) when ack arrives in the first ISSUE cycle.
//   - 2 cycles for a refractory neuron.
//  No backpressure on spikes: spike_vld_o is a 1-cycle pulse in WB.
//  dp_v_next_i is used as delivered; the datapath saturates, the scheduler does no arithmetic on it.
//  tick_i while busy_o = 1 (including in DONE): ignored, overrun_o set, cleared only by reset.
//  cfg writes:
//   - Accepted any cycle and take effect the next cycle.
//   - A write to the index in ISSUE does not change dp_i_o mid-handshake; it is used next tick.
//  Reset asserted mid-sweep: immediate return to reset values; any pending handshake is dropped.
// CONFIGURATION
//  NEURON_SCHED_REFRAC_EN defined:
//   - refractory counters exist; behaviour as above.
//  NEURON_SCHED_REFRAC_EN undefined:
//   - no refractory storage; SEL always goes to ISSUE.
//   - A spike still resets V to V_RESET, but the neuron is updated again on the next tick.
// STRUCTURE
//  Package neuron_sched_pkg:
//   - state enum sched_state_t.
//   - Q-format constant FRAC_BITS = 8.
//   - typedefs v_t (signed [V_W-1:0]) and idx_t.
//  Sub-module neuron_state_rf holds the V, bias and refractory arrays:
//   - one read port addressed by idx, one FSM write port, one cfg bias write port.
//   - async reset to the reset values above.
//  The FSM, compare and handshake logic live in neuron_array_sched.
// TESTING
//  1. Reset, bias 0, datapath echoes v_next = v, one tick:
//     - 16 handshakes, no spikes, done_o after 16*3+1 cycles.
//     - All V remain -16640.
//  2. Neuron 3: datapath returns -9829 (> V_THRESH):
//     - spike_vld_o with idx 3.
//     - V[3] = -16640 and neuron 3 issues no dp_req_o for the next 5 ticks, then resumes.
//  3. Datapath returns exactly -9830 for neuron 0: no spike, V[0] = -9830.
//  4. ack delayed 4 cycles for neuron 7:
//     - dp_req_o, dp_idx_o = 7, dp_v_o and dp_i_o held stable for 4 cycles.
//     - The sweep completes correctly.
//  5. tick_i pulsed mid-sweep: overrun_o = 1 and stays 1; the sweep count is unchanged (one done_o).
//  6. rst_n low during ISSUE for neuron 5:
//     - dp_req_o drops immediately; all V = -16640.
//     - The next tick sweeps from idx 0.

Source files
------------

// File: rtl/neuron_sched_pkg.sv
// Shared types for the neuron array scheduler: FSM state enum, Q8.8 format constant
// and default-width voltage/index typedefs.
package neuron_sched_pkg;

    localparam int FRAC_BITS       = 8;
    localparam int DEF_V_W         = 16;
    localparam int DEF_NUM_NEURONS = 16;
    localparam int DEF_IDX_W       = $clog2(DEF_NUM_NEURONS);

    typedef logic signed [DEF_V_W-1:0] v_t;
    typedef logic [DEF_IDX_W-1:0]      idx_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_ISSUE,
        S_WB,
        S_DONE
    } sched_state_t;

endpackage

// File: rtl/neuron_state_rf.sv
// Per-neuron state storage: membrane voltage, bias current and (with NEURON_SCHED_REFRAC_EN)
// refractory count. One read port, one FSM write port, one bias config write port.
module neuron_state_rf
    import neuron_sched_pkg::*;
#(
    parameter int                      NUM_NEURONS = 16,
    parameter int                      V_W         = 16,
    parameter int                      REF_W       = 3,
    parameter logic signed [V_W-1:0]   V_RESET     = -16640,
    localparam int                     IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [IDX_W-1:0]         rd_idx_i,
    output logic signed [V_W-1:0]    rd_v_o,
    output logic signed [V_W-1:0]    rd_bias_o,
    output logic [REF_W-1:0]         rd_refrac_o,
    input  logic                     wr_en_i,
    input  logic [IDX_W-1:0]         wr_idx_i,
    input  logic signed [V_W-1:0]    wr_v_i,
    input  logic [REF_W-1:0]         wr_refrac_i,
    input  logic                     cfg_we_i,
    input  logic [IDX_W-1:0]         cfg_idx_i,
    input  logic signed [V_W-1:0]    cfg_bias_i
);

    logic signed [V_W-1:0] v_q    [NUM_NEURONS];
    logic signed [V_W-1:0] v_d    [NUM_NEURONS];
    logic signed [V_W-1:0] bias_q [NUM_NEURONS];
    logic signed [V_W-1:0] bias_d [NUM_NEURONS];

    always_comb begin
        v_d    = v_q;
        bias_d = bias_q;
        if (wr_en_i)  v_d[wr_idx_i]     = wr_v_i;
        if (cfg_we_i) bias_d[cfg_idx_i] = cfg_bias_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '{default: V_RESET};
            bias_q <= '{default: '0};
        end else begin
            v_q    <= v_d;
            bias_q <= bias_d;
        end
    end

    assign rd_v_o    = v_q[rd_idx_i];
    assign rd_bias_o = bias_q[rd_idx_i];

`ifdef NEURON_SCHED_REFRAC_EN
    logic [REF_W-1:0] refrac_q [NUM_NEURONS];
    logic [REF_W-1:0] refrac_d [NUM_NEURONS];

    always_comb begin
        refrac_d = refrac_q;
        if (wr_en_i) refrac_d[wr_idx_i] = wr_refrac_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) refrac_q <= '{default: '0};
        else        refrac_q <= refrac_d;
    end

    assign rd_refrac_o = refrac_q[rd_idx_i];
`else
    logic unused_refrac;
    assign unused_refrac = ^wr_refrac_i;
    assign rd_refrac_o   = '0;
`endif

endmodule

// File: rtl/neuron_array_sched.sv
// Sweeps NUM_NEURONS LIF state slots through one shared datapath per tick over req/ack.
// Refractory hold is compiled in only when NEURON_SCHED_REFRAC_EN is defined.
module neuron_array_sched
    import neuron_sched_pkg::*;
#(
    parameter int                    NUM_NEURONS = 16,
    parameter int                    V_W         = 16,
    parameter logic signed [V_W-1:0] V_THRESH    = -9830,
    parameter logic signed [V_W-1:0] V_RESET     = -16640,
    parameter int                    REFRAC_CYC  = 5,
    localparam int                   IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick_i,
    input  logic                  cfg_we_i,
    input  logic [IDX_W-1:0]      cfg_idx_i,
    input  logic signed [V_W-1:0] cfg_bias_i,
    output logic                  dp_req_o,
    output logic [IDX_W-1:0]      dp_idx_o,
    output logic signed [V_W-1:0] dp_v_o,
    output logic signed [V_W-1:0] dp_i_o,
    input  logic                  dp_ack_i,
    input  logic signed [V_W-1:0] dp_v_next_i,
    output logic                  spike_vld_o,
    output logic [IDX_W-1:0]      spike_idx_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overrun_o
);

    localparam int               REF_W    = $clog2(REFRAC_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    sched_state_t          state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic signed [V_W-1:0] dp_v_q, dp_v_d, dp_i_q, dp_i_d, v_next_q, v_next_d;
    logic                  skip_q, skip_d, overrun_q, overrun_d;

    logic signed [V_W-1:0] rd_v, rd_bias, wr_v;
    logic [REF_W-1:0]      rd_refrac, wr_refrac;
    logic                  wr_en, spike;

    neuron_state_rf #(
        .NUM_NEURONS (NUM_NEURONS),
        .V_W         (V_W),
        .REF_W       (REF_W),
        .V_RESET     (V_RESET)
    ) u_rf (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_idx_i    (idx_q),
        .rd_v_o      (rd_v),
        .rd_bias_o   (rd_bias),
        .rd_refrac_o (rd_refrac),
        .wr_en_i     (wr_en),
        .wr_idx_i    (idx_q),
        .wr_v_i      (wr_v),
        .wr_refrac_i (wr_refrac),
        .cfg_we_i    (cfg_we_i),
        .cfg_idx_i   (cfg_idx_i),
        .cfg_bias_i  (cfg_bias_i)
    );

    assign spike = (state_q == S_WB) && !skip_q && (v_next_q > V_THRESH);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dp_v_d    = dp_v_q;
        dp_i_d    = dp_i_q;
        v_next_d  = v_next_q;
        skip_d    = skip_q;
        overrun_d = overrun_q | (tick_i && (state_q != S_IDLE));
        wr_en     = 1'b0;
        wr_v      = V_RESET;
        wr_refrac = '0;
        unique case (state_q)
            S_IDLE: begin
                if (tick_i) begin
                    state_d = S_SEL;
                    idx_d   = '0;
                end
            end
            S_SEL: begin
                // Operands are latched so a bias write during the handshake cannot disturb dp_i_o.
                dp_v_d  = rd_v;
                dp_i_d  = rd_bias;
                skip_d  = (rd_refrac != '0);
                state_d = (rd_refrac != '0) ? S_WB : S_ISSUE;
            end
            S_ISSUE: begin
                if (dp_ack_i) begin
                    v_next_d = dp_v_next_i;
                    state_d  = S_WB;
                end
            end
            S_WB: begin
                wr_en = 1'b1;
                if (skip_q) begin
                    wr_refrac = rd_refrac - 1'b1;
                end else if (spike) begin
                    wr_refrac = REF_W'(REFRAC_CYC);
                end else begin
                    wr_v = v_next_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_SEL;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            dp_v_q    <= '0;
            dp_i_q    <= '0;
            v_next_q  <= '0;
            skip_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dp_v_q    <= dp_v_d;
            dp_i_q    <= dp_i_d;
            v_next_q  <= v_next_d;
            skip_q    <= skip_d;
            overrun_q <= overrun_d;
        end
    end

    assign dp_req_o    = (state_q == S_ISSUE);
    assign dp_idx_o    = idx_q;
    assign dp_v_o      = dp_v_q;
    assign dp_i_o      = dp_i_q;
    assign spike_vld_o = spike;
    assign spike_idx_o = idx_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_neuron_array_sched.sv
// Bench for neuron_array_sched: the bench plays the datapath and checks every handshake,
// spike and sweep length against a per-tick neuron model (honours NEURON_SCHED_REFRAC_EN).
module tb_neuron_array_sched;

    localparam int N          = 16;
    localparam int V_THRESH   = -9830;
    localparam int V_RESET    = -16640;
    localparam int REFRAC_CYC = 5;
`ifdef NEURON_SCHED_REFRAC_EN
    localparam bit REFRAC_ON = 1'b1;
`else
    localparam bit REFRAC_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               tick_i = 1'b0;
    logic               cfg_we_i = 1'b0;
    logic [3:0]         cfg_idx_i = '0;
    logic signed [15:0] cfg_bias_i = '0;
    logic               dp_req_o;
    logic [3:0]         dp_idx_o;
    logic signed [15:0] dp_v_o, dp_i_o;
    logic               dp_ack_i = 1'b0;
    logic signed [15:0] dp_v_next_i = '0;
    logic               spike_vld_o;
    logic [3:0]         spike_idx_o;
    logic               busy_o, done_o, overrun_o;

    int total = 0;
    int bad   = 0;

    int m_v[N], m_bias[N], m_ref[N];
    int resp_v[N], delay[N];

    always #5 clk = ~clk;

    neuron_array_sched dut (
        .clk(clk), .rst_n(rst_n), .tick_i(tick_i),
        .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_bias_i(cfg_bias_i),
        .dp_req_o(dp_req_o), .dp_idx_o(dp_idx_o), .dp_v_o(dp_v_o), .dp_i_o(dp_i_o),
        .dp_ack_i(dp_ack_i), .dp_v_next_i(dp_v_next_i),
        .spike_vld_o(spike_vld_o), .spike_idx_o(spike_idx_o),
        .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o)
    );

    task automatic model_reset();
        for (int n = 0; n < N; n++) begin
            m_v[n] = V_RESET; m_bias[n] = 0; m_ref[n] = 0;
            resp_v[n] = V_RESET; delay[n] = 0;
        end
    endtask

    task automatic cfg_write(input int idx, input int val);
        cfg_we_i = 1'b1; cfg_idx_i = 4'(idx); cfg_bias_i = 16'(val);
        @(negedge clk);
        cfg_we_i = 1'b0;
        m_bias[idx] = val;
    endtask

    // One full sweep; tick_at > 0 pulses tick_i again at that cycle, mid_idx >= 0 writes
    // bias mid_val to that neuron while its handshake is stalled.
    task automatic run_tick(input string tag, input int tick_at, input int mid_idx, input int mid_val);
        int want[$];
        int exp_spk[$];
        int ev[N];
        int ei[N];
        int exp_cyc, cyc, wcnt, held_v, held_i, cur;
        bit in_req, seen_done;
        exp_cyc = 1;
        for (int n = 0; n < N; n++) begin
            ev[n] = m_v[n];
            ei[n] = m_bias[n];
            if (m_ref[n] > 0) begin
                m_ref[n]--;
                m_v[n] = V_RESET;
                exp_cyc += 2;
            end else begin
                want.push_back(n);
                exp_cyc += 3 + delay[n];
                if (resp_v[n] > V_THRESH) begin
                    exp_spk.push_back(n);
                    m_v[n] = V_RESET;
                    if (REFRAC_ON) m_ref[n] = REFRAC_CYC;
                end else begin
                    m_v[n] = resp_v[n];
                end
            end
        end
        if (mid_idx >= 0) m_bias[mid_idx] = mid_val;

        tick_i = 1'b1;
        cyc = 0; in_req = 0; seen_done = 0; cur = 0; wcnt = 0; held_v = 0; held_i = 0;
        while (!seen_done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            tick_i   = (cyc == tick_at);
            cfg_we_i = 1'b0;
            dp_ack_i = 1'b0;
            if (spike_vld_o) begin
                total++;
                if (exp_spk.size() == 0 || int'(spike_idx_o) != exp_spk[0]) begin
                    bad++;
                    $display("FAIL %s spike_idx got=%0d want=%0d", tag, spike_idx_o,
                             exp_spk.size() > 0 ? exp_spk[0] : -1);
                end
                if (exp_spk.size() > 0) void'(exp_spk.pop_front());
            end
            if (dp_req_o) begin
                if (!in_req) begin
                    in_req = 1; wcnt = 0;
                    cur = int'(dp_idx_o); held_v = int'(dp_v_o); held_i = int'(dp_i_o);
                    total++;
                    if (want.size() == 0 || cur != want[0]) begin
                        bad++;
                        $display("FAIL %s req_idx got=%0d want=%0d", tag, cur,
                                 want.size() > 0 ? want[0] : -1);
                    end
                    if (want.size() > 0) void'(want.pop_front());
                    total++;
                    if (held_v != ev[cur] || held_i != ei[cur]) begin
                        bad++;
                        $display("FAIL %s operands idx=%0d got v=%0d i=%0d want v=%0d i=%0d",
                                 tag, cur, held_v, held_i, ev[cur], ei[cur]);
                    end
                end else begin
                    total++;
                    if (int'(dp_idx_o) != cur || int'(dp_v_o) != held_v || int'(dp_i_o) != held_i) begin
                        bad++;
                        $display("FAIL %s hold idx got=%0d/%0d/%0d want=%0d/%0d/%0d", tag,
                                 dp_idx_o, dp_v_o, dp_i_o, cur, held_v, held_i);
                    end
                end
                if (mid_idx >= 0 && cur == mid_idx && wcnt == 0 && delay[cur] > 0) begin
                    cfg_we_i = 1'b1; cfg_idx_i = 4'(mid_idx); cfg_bias_i = 16'(mid_val);
                end
                if (wcnt >= delay[cur]) begin
                    dp_ack_i = 1'b1;
                    dp_v_next_i = 16'(resp_v[cur]);
                    in_req = 0;
                end else begin
                    wcnt++;
                end
            end
            if (done_o) begin
                seen_done = 1;
                total++;
                if (cyc != exp_cyc) begin
                    bad++;
                    $display("FAIL %s done_cycle got=%0d want=%0d", tag, cyc, exp_cyc);
                end
            end
        end
        tick_i = 1'b0; cfg_we_i = 1'b0; dp_ack_i = 1'b0;
        total++;
        if (!seen_done) begin
            bad++;
            $display("FAIL %s done_timeout got=none want=done_o within 2000 cycles", tag);
        end
        total++;
        if (want.size() != 0 || exp_spk.size() != 0) begin
            bad++;
            $display("FAIL %s leftovers got reqs_missing=%0d spikes_missing=%0d want=0/0",
                     tag, want.size(), exp_spk.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({dp_req_o, dp_idx_o, dp_v_o, dp_i_o, spike_vld_o, spike_idx_o, busy_o, done_o, overrun_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got req=%b idx=%0d v=%0d i=%0d spk=%b busy=%b done=%b ovr=%b want all 0",
                     dp_req_o, dp_idx_o, dp_v_o, dp_i_o, spike_vld_o, busy_o, done_o, overrun_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy_o !== 1'b0 || overrun_o !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle got busy=%b ovr=%b want 0/0", busy_o, overrun_o);
        end
    endtask

    task automatic test_echo();
        for (int t = 0; t < 2; t++) begin
            for (int n = 0; n < N; n++) begin resp_v[n] = m_v[n]; delay[n] = 0; end
            run_tick("echo", 0, -1, 0);
        end
    endtask

    task automatic test_spike_refrac();
        for (int n = 0; n < N; n++) resp_v[n] = -12000;
        resp_v[3] = -9829;
        run_tick("spike3", 0, -1, 0);
        resp_v[3] = -12000;
        for (int t = 0; t < 7; t++) run_tick("refrac", 0, -1, 0);
    endtask

    task automatic test_threshold_equal();
        for (int n = 0; n < N; n++) resp_v[n] = -12000;
        resp_v[0] = V_THRESH;
        run_tick("thresh_eq", 0, -1, 0);
        run_tick("thresh_eq_next", 0, -1, 0);
    endtask

    task automatic test_ack_delay();
        cfg_write(7, 1234);
        delay[7] = 4;
        run_tick("ack_delay", 0, 7, 291);
        delay[7] = 0;
        run_tick("ack_delay_next", 0, -1, 0);
    endtask

    task automatic test_overrun();
        run_tick("overrun", 10, -1, 0);
        total++;
        if (overrun_o !== 1'b1) begin
            bad++;
            $display("FAIL overrun_set got=%b want=1", overrun_o);
        end
        for (int c = 0; c < 4; c++) begin
            total++;
            if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                bad++;
                $display("FAIL overrun_extra_sweep got done=%b busy=%b want 0/0", done_o, busy_o);
            end
            @(negedge clk);
        end
        run_tick("overrun_after", 0, -1, 0);
        total++;
        if (overrun_o !== 1'b1) begin
            bad++;
            $display("FAIL overrun_sticky got=%b want=1", overrun_o);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < 3; k++)
                cfg_write(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 4000)) - 2000);
            for (int n = 0; n < N; n++) begin
                delay[n] = int'($urandom_range(0, 2));
                case ($urandom_range(0, 5))
                    0:       resp_v[n] = V_THRESH + int'($urandom_range(1, 3000));
                    1:       resp_v[n] = V_THRESH;
                    default: resp_v[n] = -22000 + int'($urandom_range(0, 12000));
                endcase
            end
            run_tick("random", 0, -1, 0);
        end
    endtask

    task automatic test_reset_mid_issue();
        int cyc;
        bit hit;
        for (int n = 0; n < N; n++) begin resp_v[n] = -20000; delay[n] = 0; end
        tick_i = 1'b1; cyc = 0; hit = 0;
        while (!hit && cyc < 200) begin
            @(negedge clk);
            cyc++;
            tick_i = 1'b0; dp_ack_i = 1'b0;
            if (dp_req_o) begin
                if (dp_idx_o == 4'd5) hit = 1;
                else begin dp_ack_i = 1'b1; dp_v_next_i = -16'sd20000; end
            end
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL rst_mid_reach got=no req idx5 want=req idx5");
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (dp_req_o !== 1'b0 || busy_o !== 1'b0 || overrun_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_drop got req=%b busy=%b ovr=%b want 0/0/0", dp_req_o, busy_o, overrun_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
        run_tick("after_reset", 0, -1, 0);
    endtask

    initial begin
        test_reset();
        test_echo();
        test_spike_refrac();
        test_threshold_equal();
        test_ack_delay();
        test_overrun();
        test_random();
        test_reset_mid_issue();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
